soc_mem_copy_dma: RTL and testbench

- Word-copy DMA engine; initiator (master) side of the single-port 32-bit SoC memory interface.
- Reads N words from a source window and writes them to a destination window; one outstanding transfer at a time.
- Sits between a control register block and the memory responder (on-chip RAM or peripherals). Frees the core from memcpy/memset loops.

---
 rtl/soc_mem_copy_dma.sv | 196 +++++++++++++++++++
 tb/tb_soc_mem_copy_dma.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_mem_copy_dma.sv
// soc_mem_copy_dma: word-copy DMA initiator on the single-port 32-bit SoC memory bus.
// Copies i_len words from a source to a destination window, one bus request at a time.
// Optional memset mode is compiled in with macro SOC_DMA_FILL_EN (adds i_fill/i_fill_val).
module soc_mem_copy_dma #(
   parameter int unsigned p_len_w   = 16,
   parameter logic [3:0]  p_be_full = 4'hF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [31:2]        i_src_addr,
   input  logic [31:2]        i_dst_addr,
   input  logic [p_len_w-1:0] i_len,
`ifdef SOC_DMA_FILL_EN
   input  logic               i_fill,
   input  logic [31:0]        i_fill_val,
`endif
   output logic               o_busy,
   output logic               o_done,
   output logic [p_len_w-1:0] o_words_done,
   output logic [31:2]        o_mem_addr,
   output logic [3:0]         o_mem_be,
   output logic               o_mem_wr_en,
   output logic [31:0]        o_mem_wr_data,
   output logic               o_mem_rd_en,
   input  logic [31:0]        i_mem_rd_data,
   input  logic               i_mem_busy,
   input  logic               i_mem_ack
);

   localparam int unsigned lp_aw = 30;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_CAP,
      S_WR_REQ,
      S_DONE
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [lp_aw-1:0]     r_src, w_src_nxt;
   logic [lp_aw-1:0]     r_dst, w_dst_nxt;
   logic [p_len_w-1:0]   r_len, w_len_nxt;
   logic [p_len_w-1:0]   r_words, w_words_nxt;
   logic [lp_aw-1:0]     r_addr, w_addr_nxt;
   logic [3:0]           r_be, w_be_nxt;
   logic                 r_wr_en, w_wr_en_nxt;
   logic [31:0]          r_wr_data, w_wr_data_nxt;
   logic                 r_rd_en, w_rd_en_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 r_done, w_done_nxt;
   logic                 r_fill, w_fill_nxt;
   logic                 w_accept;
   logic                 w_start_fill;
   logic [31:0]          w_start_data;
   logic [p_len_w-1:0]   w_words_inc;

   assign w_accept    = (r_rd_en | r_wr_en) & ~i_mem_busy & i_mem_ack;
   assign w_words_inc = p_len_w'(r_words + 1'b1);

`ifdef SOC_DMA_FILL_EN
   assign w_start_fill = i_fill;
   assign w_start_data = i_fill_val;
`else
   assign w_start_fill = 1'b0;
   assign w_start_data = r_wr_data;
`endif

   // Next-state and next-register computation; every register defaults to hold.
   always_comb begin
      w_state_nxt   = r_state;
      w_src_nxt     = r_src;
      w_dst_nxt     = r_dst;
      w_len_nxt     = r_len;
      w_words_nxt   = r_words;
      w_addr_nxt    = r_addr;
      w_be_nxt      = r_be;
      w_wr_en_nxt   = r_wr_en;
      w_wr_data_nxt = r_wr_data;
      w_rd_en_nxt   = r_rd_en;
      w_fill_nxt    = r_fill;
      w_done_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_src_nxt   = i_src_addr;
               w_dst_nxt   = i_dst_addr;
               w_len_nxt   = i_len;
               w_words_nxt = '0;
               w_fill_nxt  = w_start_fill;
               if (i_len == '0) begin
                  w_state_nxt = S_DONE;
               end else if (w_start_fill) begin
                  // memset: the fill value lives in the write-data register
                  w_state_nxt   = S_WR_REQ;
                  w_addr_nxt    = i_dst_addr;
                  w_be_nxt      = p_be_full;
                  w_wr_en_nxt   = 1'b1;
                  w_wr_data_nxt = w_start_data;
               end else begin
                  w_state_nxt = S_RD_REQ;
                  w_addr_nxt  = i_src_addr;
                  w_rd_en_nxt = 1'b1;
               end
            end
         end
         S_RD_REQ: begin
            if (w_accept) begin
               w_rd_en_nxt = 1'b0;
               w_state_nxt = S_RD_CAP;
            end
         end
         S_RD_CAP: begin
            w_wr_data_nxt = i_mem_rd_data;
            w_addr_nxt    = r_dst;
            w_be_nxt      = p_be_full;
            w_wr_en_nxt   = 1'b1;
            w_state_nxt   = S_WR_REQ;
         end
         S_WR_REQ: begin
            if (w_accept) begin
               w_wr_en_nxt = 1'b0;
               w_be_nxt    = 4'h0;
               w_words_nxt = w_words_inc;
               w_src_nxt   = lp_aw'(r_src + 1'b1);
               w_dst_nxt   = lp_aw'(r_dst + 1'b1);
               if (w_words_inc == r_len) begin
                  w_state_nxt = S_DONE;
               end else if (r_fill) begin
                  w_wr_en_nxt = 1'b1;
                  w_be_nxt    = p_be_full;
                  w_addr_nxt  = lp_aw'(r_dst + 1'b1);
               end else begin
                  w_rd_en_nxt = 1'b1;
                  w_addr_nxt  = lp_aw'(r_src + 1'b1);
                  w_state_nxt = S_RD_REQ;
               end
            end
         end
         S_DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_rd_en_nxt = 1'b0;
            w_wr_en_nxt = 1'b0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_src     <= '0;
         r_dst     <= '0;
         r_len     <= '0;
         r_words   <= '0;
         r_addr    <= '0;
         r_be      <= 4'h0;
         r_wr_en   <= 1'b0;
         r_wr_data <= '0;
         r_rd_en   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_fill    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_src     <= w_src_nxt;
         r_dst     <= w_dst_nxt;
         r_len     <= w_len_nxt;
         r_words   <= w_words_nxt;
         r_addr    <= w_addr_nxt;
         r_be      <= w_be_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_rd_en   <= w_rd_en_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_fill    <= w_fill_nxt;
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_words_done  = r_words;
   assign o_mem_addr    = r_addr;
   assign o_mem_be      = r_be;
   assign o_mem_wr_en   = r_wr_en;
   assign o_mem_wr_data = r_wr_data;
   assign o_mem_rd_en   = r_rd_en;

endmodule

// File: tb/tb_soc_mem_copy_dma.sv
// Directed bench for soc_mem_copy_dma with a behavioural single-port memory responder.
// Exercises the SOC_DMA_FILL_EN memset mode only when that macro is defined.
module tb_soc_mem_copy_dma;

   localparam int unsigned lp_len_w = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [31:2]         src_addr = '0;
   logic [31:2]         dst_addr = '0;
   logic [lp_len_w-1:0] len = '0;
`ifdef SOC_DMA_FILL_EN
   logic                fill = 1'b0;
   logic [31:0]         fill_val = '0;
`endif
   logic                busy, done;
   logic [lp_len_w-1:0] words_done;
   logic [31:2]         mem_addr;
   logic [3:0]          mem_be;
   logic                mem_wr_en, mem_rd_en;
   logic [31:0]         mem_wr_data;
   logic [31:0]         mem_rd_data = '0;
   logic                mem_busy = 1'b0;
   logic                mem_ack;

   assign mem_ack = 1'b1;

   soc_mem_copy_dma #(.p_len_w(lp_len_w), .p_be_full(4'hF)) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_start       (start),
      .i_src_addr    (src_addr),
      .i_dst_addr    (dst_addr),
      .i_len         (len),
`ifdef SOC_DMA_FILL_EN
      .i_fill        (fill),
      .i_fill_val    (fill_val),
`endif
      .o_busy        (busy),
      .o_done        (done),
      .o_words_done  (words_done),
      .o_mem_addr    (mem_addr),
      .o_mem_be      (mem_be),
      .o_mem_wr_en   (mem_wr_en),
      .o_mem_wr_data (mem_wr_data),
      .o_mem_rd_en   (mem_rd_en),
      .i_mem_rd_data (mem_rd_data),
      .i_mem_busy    (mem_busy),
      .i_mem_ack     (mem_ack)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // Memory contents: written locations in mem, everything else from mem_init.
   logic [31:0] mem [logic [29:0]];
   int rd_cnt = 0, wr_cnt = 0, en_cyc = 0, both_cnt = 0, be_bad = 0, stab_err = 0;
   logic        pend = 1'b0;
   logic [29:0] p_addr;
   logic [31:0] p_data;
   logic [3:0]  p_be;
   logic        p_rd, p_wr;

   function automatic logic [31:0] mem_init(input logic [29:0] a);
      if (a >= 30'h100 && a <= 30'h103) return 32'hA0 + 32'(a - 30'h100);
      if (a == 30'h3FFFFFFF)            return 32'h11;
      if (a == 30'h0)                   return 32'h22;
      if (a == 30'h502)                 return 32'hCAFE0002;
      return 32'h0;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [29:0] a);
      if (mem.exists(a)) return mem[a];
      return mem_init(a);
   endfunction

   // Responder: accept, read with one-cycle latency, write, and bus-rule monitors.
   always @(posedge clk) begin
      if (rst_n) begin
         if ((mem_rd_en | mem_wr_en) && !mem_busy && mem_ack) begin
            if (mem_rd_en) begin
               rd_cnt++;
               mem_rd_data <= mem_rd(mem_addr);
            end
            if (mem_wr_en) begin
               wr_cnt++;
               if (mem_be != 4'hF) be_bad++;
               mem[mem_addr] = mem_wr_data;
            end
         end
         if (mem_rd_en | mem_wr_en) en_cyc++;
         if (mem_rd_en & mem_wr_en) both_cnt++;
         if (pend && (mem_addr != p_addr || mem_wr_data != p_data || mem_be != p_be ||
                      mem_rd_en != p_rd || mem_wr_en != p_wr)) stab_err++;
         pend   = (mem_rd_en | mem_wr_en) && (mem_busy || !mem_ack);
         p_addr = mem_addr;
         p_data = mem_wr_data;
         p_be   = mem_be;
         p_rd   = mem_rd_en;
         p_wr   = mem_wr_en;
      end else begin
         pend = 1'b0;
      end
   end

   // Stall injector: holds i_mem_busy for stall_len edges once a write hits stall_addr.
   int          stall_req = 0, stall_srv = 0, stall_len = 3, stall_cnt = 0;
   logic [29:0] stall_addr = '0;
   always @(negedge clk) begin
      if (stall_cnt > 0) begin
         stall_cnt--;
         if (stall_cnt == 0) mem_busy = 1'b0;
      end else if (stall_req != stall_srv && mem_wr_en && mem_addr == stall_addr) begin
         mem_busy  = 1'b1;
         stall_cnt = stall_len;
         stall_srv = stall_req;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_xfer(input logic [29:0] s, input logic [29:0] d, input int n);
      @(negedge clk);
      src_addr = s;
      dst_addr = d;
      len      = lp_len_w'(n);
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int base, output int lat);
      lat = -1;
      for (int k = base + 1; k <= base + 400; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   int lat, rd0, wr0, en0;

   initial begin
      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_done",  32'(done), 32'h0);
      chk("rst_words", 32'(words_done), 32'h0);
      chk("rst_addr",  32'(mem_addr), 32'h0);
      chk("rst_be",    32'(mem_be), 32'h0);
      chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
      chk("rst_data",  mem_wr_data, 32'h0);
      chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // plain 4-word copy
      rd0 = rd_cnt; wr0 = wr_cnt;
      start_xfer(30'h100, 30'h200, 4);
      wait_done(0, lat);
      chk("copy_lat", 32'(lat), 32'd13);
      chk("copy_busy_at_done", 32'(busy), 32'h0);
      chk("copy_words", 32'(words_done), 32'd4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("copy_dst%0d", k), mem_rd(30'h200 + 30'(k)), 32'hA0 + 32'(k));
      chk("copy_reads", 32'(rd_cnt - rd0), 32'd4);
      chk("copy_writes", 32'(wr_cnt - wr0), 32'd4);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'h0);
      chk("words_hold", 32'(words_done), 32'd4);

      // zero-length transfer
      rd0 = rd_cnt; wr0 = wr_cnt; en0 = en_cyc;
      start_xfer(30'h100, 30'h800, 0);
      wait_done(0, lat);
      chk("len0_lat", 32'(lat), 32'd1);
      chk("len0_words", 32'(words_done), 32'd0);
      repeat (2) @(posedge clk); #1;
      chk("len0_no_bus", 32'(en_cyc - en0), 32'd0);

      // stall for 3 cycles on word 1 write
      rd0 = rd_cnt; wr0 = wr_cnt;
      stall_addr = 30'h601; stall_len = 3; stall_req++;
      start_xfer(30'h100, 30'h600, 4);
      wait_done(0, lat);
      chk("stall_lat", 32'(lat), 32'd16);
      chk("stall_writes", 32'(wr_cnt - wr0), 32'd4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("stall_dst%0d", k), mem_rd(30'h600 + 30'(k)), 32'hA0 + 32'(k));

      // start re-pulsed mid-transfer is ignored
      start_xfer(30'h100, 30'h300, 4);
      repeat (4) @(posedge clk);
      @(negedge clk);
      src_addr = 30'h3FFFFFFF; dst_addr = 30'h400; len = 16'd2; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_done(5, lat);
      chk("restart_lat", 32'(lat), 32'd13);
      chk("restart_words", 32'(words_done), 32'd4);
      chk("restart_dst3", mem_rd(30'h303), 32'hA3);
      chk("restart_other_dst", 32'(mem.exists(30'h400)), 32'h0);

      // address wrap on source
      start_xfer(30'h3FFFFFFF, 30'h700, 2);
      wait_done(0, lat);
      chk("wrap_lat", 32'(lat), 32'd7);
      chk("wrap_dst0", mem_rd(30'h700), 32'h11);
      chk("wrap_dst1", mem_rd(30'h701), 32'h22);

      // reset during word 2 write (held off by a stall so it is never accepted)
      wr0 = wr_cnt;
      stall_addr = 30'h502; stall_len = 4; stall_req++;
      start_xfer(30'h100, 30'h500, 4);
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (mem_busy) begin lat = k; break; end
      end
      chk("rst_mid_reached", 32'(lat >= 0), 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_mid_wr_en", 32'(mem_wr_en), 32'h0);
      chk("rst_mid_rd_en", 32'(mem_rd_en), 32'h0);
      chk("rst_mid_busy",  32'(busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_mid_writes", 32'(wr_cnt - wr0), 32'd2);
      chk("rst_mid_dst0", mem_rd(30'h500), 32'hA0);
      chk("rst_mid_dst1", mem_rd(30'h501), 32'hA1);
      chk("rst_mid_dst2", mem_rd(30'h502), 32'hCAFE0002);
      start_xfer(30'h102, 30'h900, 1);
      wait_done(0, lat);
      chk("post_rst_lat", 32'(lat), 32'd4);
      chk("post_rst_dst", mem_rd(30'h900), 32'hA2);

`ifdef SOC_DMA_FILL_EN
      // memset with destination wrap
      rd0 = rd_cnt;
      @(negedge clk);
      fill = 1'b1; fill_val = 32'hDEADBEEF;
      start_xfer(30'h100, 30'h3FFFFFFF, 3);
      wait_done(0, lat);
      fill = 1'b0;
      chk("fill_lat", 32'(lat), 32'd4);
      chk("fill_reads", 32'(rd_cnt - rd0), 32'd0);
      chk("fill_w0", mem_rd(30'h3FFFFFFF), 32'hDEADBEEF);
      chk("fill_w1", mem_rd(30'h0), 32'hDEADBEEF);
      chk("fill_w2", mem_rd(30'h1), 32'hDEADBEEF);
      chk("fill_words", 32'(words_done), 32'd3);
`endif

      // bus-protocol monitors over the whole run
      chk("both_enables", 32'(both_cnt), 32'd0);
      chk("be_on_writes", 32'(be_bad), 32'd0);
      chk("held_stable", 32'(stab_err), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
